// File: rtl/watchdog_kicker.sv
// Kicks an external watchdog only when the supervised task has proven alive in the current period.
// kick is a registered pulse one cycle after the decision edge; there is no backpressure.
module watchdog_kicker #(
  parameter int LENGTH    = 5,
  parameter int COUNT     = 20,
  parameter int THRESHOLD = COUNT - 10,
  parameter int KICK_AT   = (THRESHOLD + COUNT) / 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       heartbeat,
  input  logic       timeout,
  output logic       kick,
  output logic       missed,
  output logic [1:0] state,
  output logic [7:0] kick_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    STARVE  = 2'd2,
    TRIPPED = 2'd3
  } state_t;

  localparam bit PARAMS_OK = (COUNT < 2 ** LENGTH) && (THRESHOLD <= KICK_AT) &&
                             (KICK_AT < COUNT - 1);

  localparam logic [LENGTH-1:0] LATE_C = LENGTH'(COUNT - 1);
  localparam logic [LENGTH-1:0] KICK_C = LENGTH'(KICK_AT);

  if (!PARAMS_OK) begin : g_param_check
    $error("watchdog_kicker: inconsistent LENGTH/COUNT/THRESHOLD/KICK_AT");
  end

  state_t            st;
  logic [LENGTH-1:0] cnt;
  logic              hb_seen;
  logic              kick_go;

  // A same-cycle heartbeat counts, so a pulse landing exactly on LATE still earns a kick.
  assign kick_go = (cnt >= KICK_C) && (hb_seen || heartbeat);
  assign state   = st;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st       <= IDLE;
      cnt      <= '0;
      hb_seen  <= 1'b0;
      kick     <= 1'b0;
      missed   <= 1'b0;
      kick_cnt <= 8'd0;
    end else begin
      kick <= 1'b0;
      if (st != IDLE && !enable) begin
        st      <= IDLE;
        cnt     <= '0;
        hb_seen <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            cnt     <= '0;
            hb_seen <= 1'b0;
            if (enable) begin
              st       <= ARMED;
              missed   <= 1'b0;
              kick_cnt <= 8'd0;
            end
          end
          ARMED: begin
            if (timeout) begin
              st     <= TRIPPED;
              missed <= 1'b1;
            end else if (kick_go) begin
              kick    <= 1'b1;
              cnt     <= '0;
              hb_seen <= 1'b0;
              if (kick_cnt != 8'hFF) kick_cnt <= kick_cnt + 8'd1;
            end else if (cnt == LATE_C) begin
              st     <= STARVE;
              missed <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
              if (heartbeat) hb_seen <= 1'b1;
            end
          end
          STARVE: begin
            if (timeout) st <= TRIPPED;
          end
          TRIPPED: st <= TRIPPED;
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_watchdog_kicker.sv
// Directed bench for watchdog_kicker with an in-bench watchdog for closed-loop runs.
module tb_watchdog_kicker;
  localparam int COUNT = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       heartbeat = 1'b0;
  logic       timeout_tb = 1'b0;
  logic       loop_mode = 1'b0;
  logic       kick, missed;
  logic [1:0] state;
  logic [7:0] kick_cnt;
  logic [4:0] wd_cnt = 5'd0;
  logic       wd_timeout, dut_timeout;
  logic       prev_kick;
  int         total = 0;
  int         bad = 0;
  int         kicks, to_cycles, dbl, waited;
  logic       saw_to;

  always #5 clk = ~clk;

  // Reference watchdog: times out COUNT cycles after its last kick.
  assign wd_timeout  = (wd_cnt == 5'(COUNT));
  assign dut_timeout = loop_mode ? wd_timeout : timeout_tb;

  always_ff @(posedge clk) begin
    if (!enable) wd_cnt <= 5'd0;
    else if (kick) wd_cnt <= 5'd0;
    else if (wd_cnt != 5'(COUNT)) wd_cnt <= wd_cnt + 5'd1;
  end

  watchdog_kicker dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .heartbeat(heartbeat),
    .timeout  (dut_timeout),
    .kick     (kick),
    .missed   (missed),
    .state    (state),
    .kick_cnt (kick_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    // reset state and idle hold after release
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_kick", 32'(kick), 0);
    chk("rst_missed", 32'(missed), 0);
    chk("rst_kick_cnt", 32'(kick_cnt), 0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_hold", 32'(state), 0);

    // heartbeat at cnt=3 every period: kick every 16 edges
    enable = 1'b1; tick();
    chk("arm_state", 32'(state), 1);
    for (int e = 1; e <= 48; e++) begin
      heartbeat = ((e - 1) % 16 == 3);
      tick();
      heartbeat = 1'b0;
      chk($sformatf("p16_kick_e%0d", e), 32'(kick), (e % 16 == 0) ? 1 : 0);
      if (e == 16) begin
        chk("p16_kick_cnt1", 32'(kick_cnt), 1);
        chk("p16_state", 32'(state), 1);
      end
    end
    chk("p16_kick_cnt3", 32'(kick_cnt), 3);
    enable = 1'b0; tick();
    chk("dis_state", 32'(state), 0);
    chk("dis_kick_cnt_hold", 32'(kick_cnt), 3);

    // late heartbeat at cnt=17
    enable = 1'b1; tick();
    chk("rearm_kick_cnt", 32'(kick_cnt), 0);
    for (int e = 1; e <= 18; e++) begin
      heartbeat = (e == 18);
      tick();
      heartbeat = 1'b0;
      chk($sformatf("late_kick_e%0d", e), 32'(kick), (e == 18) ? 1 : 0);
    end
    chk("late_state", 32'(state), 1);
    enable = 1'b0; tick();

    // starvation, ignored heartbeat, timeout, disable
    enable = 1'b1; tick();
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk($sformatf("starve_kick_e%0d", e), 32'(kick), 0);
      if (e == 19) begin
        chk("pre_starve_state", 32'(state), 1);
        chk("pre_starve_missed", 32'(missed), 0);
      end
    end
    chk("starve_state", 32'(state), 2);
    chk("starve_missed", 32'(missed), 1);
    heartbeat = 1'b1;
    repeat (3) begin
      tick();
      chk("starve_hb_kick", 32'(kick), 0);
    end
    heartbeat = 1'b0;
    chk("starve_hb_state", 32'(state), 2);
    timeout_tb = 1'b1; tick(); timeout_tb = 1'b0;
    chk("tripped_state", 32'(state), 3);
    tick();
    chk("tripped_hold", 32'(state), 3);
    chk("tripped_kick", 32'(kick), 0);
    enable = 1'b0; tick();
    chk("trip_dis_state", 32'(state), 0);
    chk("trip_dis_missed", 32'(missed), 1);
    enable = 1'b1; tick();
    chk("rearm_missed_clr", 32'(missed), 0);
    chk("rearm_state", 32'(state), 1);

    // heartbeat coincident with cnt=LATE wins over starvation
    for (int e = 1; e <= 20; e++) begin
      heartbeat = (e == 20);
      tick();
      heartbeat = 1'b0;
      chk($sformatf("late19_kick_e%0d", e), 32'(kick), (e == 20) ? 1 : 0);
    end
    chk("late19_state", 32'(state), 1);
    chk("late19_missed", 32'(missed), 0);
    chk("late19_kick_cnt", 32'(kick_cnt), 1);

    // timeout in ARMED suppresses the same-cycle kick
    for (int e = 1; e <= 15; e++) begin
      heartbeat = (e == 4);
      tick();
      heartbeat = 1'b0;
    end
    timeout_tb = 1'b1; tick(); timeout_tb = 1'b0;
    chk("to_armed_kick", 32'(kick), 0);
    chk("to_armed_state", 32'(state), 3);
    chk("to_armed_missed", 32'(missed), 1);
    chk("to_armed_kick_cnt", 32'(kick_cnt), 1);
    enable = 1'b0; tick();

    // reset on a kick-decision edge
    enable = 1'b1; tick();
    for (int e = 1; e <= 31; e++) begin
      heartbeat = ((e - 1) % 16 == 3);
      tick();
      heartbeat = 1'b0;
    end
    chk("pre_rst_kick_cnt", 32'(kick_cnt), 1);
    reset_n = 1'b0; tick();
    chk("rst_kick_kick", 32'(kick), 0);
    chk("rst_kick_state", 32'(state), 0);
    chk("rst_kick_kick_cnt", 32'(kick_cnt), 0);
    chk("rst_kick_missed", 32'(missed), 0);
    enable = 1'b0; reset_n = 1'b1;
    tick(); tick();
    chk("post_rst_state", 32'(state), 0);

    // closed loop with the reference watchdog
    loop_mode = 1'b1; enable = 1'b1;
    kicks = 0; to_cycles = 0; dbl = 0; prev_kick = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      heartbeat = (c % 16 == 1);
      tick();
      heartbeat = 1'b0;
      if (kick) kicks++;
      if (kick && prev_kick) dbl++;
      prev_kick = kick;
      if (wd_timeout) to_cycles++;
    end
    chk("loop_timeouts", 32'(to_cycles), 0);
    chk("loop_kicks", 32'(kicks), 62);
    chk("loop_kick_cnt", 32'(kick_cnt), 62);
    chk("loop_double_kick", 32'(dbl), 0);
    chk("loop_state", 32'(state), 1);
    waited = 0; saw_to = 1'b0;
    while (state != 2'd3 && waited < 200) begin
      tick();
      if (wd_timeout) saw_to = 1'b1;
      waited++;
    end
    chk("noheart_tripped", 32'(state), 3);
    chk("noheart_wd_timeout", 32'(saw_to), 1);
    chk("noheart_missed", 32'(missed), 1);
    loop_mode = 1'b0; enable = 1'b0; tick();

    // kick_cnt saturation with heartbeat held high
    enable = 1'b1; heartbeat = 1'b1;
    dbl = 0; prev_kick = 1'b0;
    repeat (16 * 260 + 1) begin
      tick();
      if (kick && prev_kick) dbl++;
      prev_kick = kick;
    end
    chk("sat_kick_cnt", 32'(kick_cnt), 255);
    chk("sat_state", 32'(state), 1);
    chk("sat_double_kick", 32'(dbl), 0);
    heartbeat = 1'b0; enable = 1'b0; tick();
    chk("sat_hold", 32'(kick_cnt), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/watchdog_kicker.md
WATCHDOG_KICKER -- requirements
Module: watchdog_kicker

Interface
REQ-001 Parameter LENGTH, default 5: counter width in bits; SHALL match the supervising watchdog.
REQ-002 Parameter COUNT, default 20: watchdog timeout count; SHALL satisfy COUNT < 2**LENGTH.
REQ-003 Parameter THRESHOLD, default COUNT-10: earliest count at which a kick is allowed.
REQ-004 Parameter KICK_AT, default (THRESHOLD+COUNT)/2 = 15: nominal kick count; SHALL satisfy THRESHOLD <= KICK_AT < COUNT-1.
REQ-005 clk  input  1  clock; all state changes occur on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 enable  input  1  level; 1 = supervise and kick, 0 = idle.
REQ-008 heartbeat  input  1  pulse from the supervised task meaning "alive".
REQ-009 timeout  input  1  watchdog timeout feedback, active high.
REQ-010 kick  output  1  registered one-cycle pulse to the watchdog kick input.
REQ-011 missed  output  1  sticky flag: a heartbeat deadline was missed.
REQ-012 state  output  2  FSM state: IDLE=0, ARMED=1, STARVE=2, TRIPPED=3.
REQ-013 kick_cnt  output  8  saturating count of kicks issued since leaving IDLE.

Function
REQ-014 Internal counter cnt[LENGTH-1:0] and flag hb_seen; LATE = COUNT-1 is the last safe kick count.
REQ-015 kick SHALL be 0 on every cycle except the one following a kick decision; it is never high for two consecutive cycles.
REQ-016 IDLE: cnt=0, hb_seen=0, kick=0; when enable=1, go to ARMED with cnt=0, hb_seen=0, missed=0, kick_cnt=0.
REQ-017 ARMED: cnt increments by 1 per cycle; heartbeat=1 sets hb_seen.
REQ-018 ARMED kick decision: if cnt >= KICK_AT and (hb_seen or heartbeat), set kick=1, cnt=0, hb_seen=0, and kick_cnt increments (saturates at 255); stay in ARMED.
REQ-019 A heartbeat in a kick-decision cycle SHALL be consumed by that kick and not carried into the next period.
REQ-020 A heartbeat while cnt < KICK_AT SHALL only set hb_seen; a kick SHALL never be issued with cnt < KICK_AT.
REQ-021 ARMED starvation: if cnt == LATE and no heartbeat (hb_seen=0, heartbeat=0), go to STARVE with missed=1 and no kick.
REQ-022 When cnt == LATE and heartbeat=1, the kick decision (REQ-018) takes priority over starvation.
REQ-023 STARVE: cnt holds; heartbeat is ignored; no kicks. timeout=1 goes to TRIPPED.
REQ-024 TRIPPED: no kicks; cnt holds; the state persists until enable=0 or reset.
REQ-025 timeout=1 while in ARMED SHALL go to TRIPPED, set missed=1, and suppress any same-cycle kick.
REQ-026 enable=0 in any non-IDLE state SHALL go to IDLE next cycle with kick=0, cnt=0, hb_seen=0; missed and kick_cnt hold until the next IDLE->ARMED transition.
REQ-027 Priority per cycle: reset_n=0 > enable=0 > timeout=1 > kick decision > starvation > increment.
REQ-028 cnt SHALL never wrap; in ARMED it is bounded by LATE.

Reset
REQ-029 When reset_n=0 at a clock edge: state=IDLE, cnt=0, hb_seen=0, kick=0, missed=0, kick_cnt=0; this overrides all other inputs, including mid-kick.
REQ-030 After reset release, the block SHALL remain in IDLE until enable=1 is sampled.

Verification (defaults: COUNT=20, THRESHOLD=10, KICK_AT=15, LATE=19)
REQ-031 Enable at edge E0, heartbeat pulse at cnt=3 -> kick high for exactly one cycle after edge E0+16, state stays 1, kick_cnt=1; with a heartbeat every period, the kick period is 16 cycles.
REQ-032 Heartbeat pulse only at cnt=17 -> kick after the edge that samples cnt=17 (18 edges after entry); no kick at cnt=15.
REQ-033 No heartbeat -> at the edge sampling cnt=19: state=2, missed=1, kick stays 0; then timeout=1 -> state=3; then enable=0 -> state=0, missed still 1.
REQ-034 Heartbeat coincident with cnt=19 -> kick issued, state stays 1, missed=0.
REQ-035 reset_n=0 in the same cycle as a kick decision -> kick stays 0 and all outputs return to their reset values.
REQ-036 Closed loop with a watchdog instance of the same parameters and a heartbeat every period -> watchdog timeout never asserts over 1000 cycles; with the heartbeat removed, timeout asserts and the kicker reaches TRIPPED.
